// File: rtl/demux2x4_8bits_pkg.sv
// Shared definitions for the lane demux: default width, FSM states and
// slot encodings. The slot values match the 4x2 lane mux on the transmit side.
package demux2x4_8bits_pkg;

  localparam int unsigned BW = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic SLOT_EVEN = 1'b0;
  localparam logic SLOT_ODD  = 1'b1;

endpackage

// File: rtl/demux2x4_8bits_demux1x2.sv
// One lane -> two channels.
// The even-slot word is held in a stage register. On the odd slot, both
// channel outputs load together: A from the stage register, B straight from
// the lane. An invalid word clears the channel valid and keeps its data.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   cap_even_i          load the stage register from the lane
//   load_odd_i          load both channel outputs
//   data_i / valid_i    lane word
//   data_a_o / valid_a_o  even-slot channel
//   data_b_o / valid_b_o  odd-slot channel
module demux1x2_8bits #(
  parameter int unsigned BW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cap_even_i,
  input  logic          load_odd_i,
  input  logic [BW-1:0] data_i,
  input  logic          valid_i,
  output logic [BW-1:0] data_a_o,
  output logic          valid_a_o,
  output logic [BW-1:0] data_b_o,
  output logic          valid_b_o
);

  logic [BW-1:0] stg_d_q;
  logic          stg_v_q;
  logic [BW-1:0] a_d_q, b_d_q;
  logic          a_v_q, b_v_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stg_d_q <= '0;
      stg_v_q <= 1'b0;
      a_d_q   <= '0;
      a_v_q   <= 1'b0;
      b_d_q   <= '0;
      b_v_q   <= 1'b0;
    end else begin
      if (cap_even_i) begin
        stg_d_q <= data_i;
        stg_v_q <= valid_i;
      end
      if (load_odd_i) begin
        a_v_q <= stg_v_q;
        if (stg_v_q) a_d_q <= stg_d_q;
        b_v_q <= valid_i;
        if (valid_i) b_d_q <= data_i;
      end
    end
  end

  assign data_a_o  = a_d_q;
  assign valid_a_o = a_v_q;
  assign data_b_o  = b_d_q;
  assign valid_b_o = b_v_q;

endmodule

// File: rtl/demux2x4_8bits.sv
// Receive-side 2x4 lane demux. Two interleaved lanes at clk_2f are split into
// four channels that update every second edge.
// Lane 00 carries ch0 and ch1. Lane 11 carries ch2 and ch3.
// Ports:
//   clk_2f, reset           clock (2x channel rate), async active-high reset
//   data_00/valid_00        lane 00 (ch0 even slot, ch1 odd slot)
//   data_11/valid_11        lane 11 (ch2 even slot, ch3 odd slot)
//   data_0..3/valid_0..3    registered channel outputs
//   out_stb                 high for the cycle after an output update
//   phase                   current slot, 0 = even, 1 = odd
module demux2x4_8bits
  import demux2x4_8bits_pkg::*;
#(
  parameter int unsigned BW = demux2x4_8bits_pkg::BW
) (
  input  logic          clk_2f,
  input  logic          reset,
  input  logic [BW-1:0] data_00,
  input  logic          valid_00,
  input  logic [BW-1:0] data_11,
  input  logic          valid_11,
  output logic [BW-1:0] data_0,
  output logic [BW-1:0] data_1,
  output logic [BW-1:0] data_2,
  output logic [BW-1:0] data_3,
  output logic          valid_0,
  output logic          valid_1,
  output logic          valid_2,
  output logic          valid_3,
  output logic          out_stb,
  output logic          phase
);

  state_e state_q, state_d;
  logic   phase_q, phase_d;
  logic   out_stb_q;
  logic   cap_even, load_odd;
  logic   any_valid;

  assign any_valid = valid_00 | valid_11;

  // The first valid word seen in IDLE defines the even slot. After that the
  // slot simply alternates, and idle traffic never realigns it.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cap_even = 1'b0;
    load_odd = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        phase_d = SLOT_EVEN;
        if (any_valid) begin
          cap_even = 1'b1;
          phase_d  = SLOT_ODD;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        phase_d  = ~phase_q;
        cap_even = (phase_q == SLOT_EVEN);
        load_odd = (phase_q == SLOT_ODD);
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = SLOT_EVEN;
      end
    endcase
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= SLOT_EVEN;
      out_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      out_stb_q <= load_odd;
    end
  end

  demux1x2_8bits #(.BW(BW)) u_lane00 (
    .clk_i      (clk_2f),
    .rst_i      (reset),
    .cap_even_i (cap_even),
    .load_odd_i (load_odd),
    .data_i     (data_00),
    .valid_i    (valid_00),
    .data_a_o   (data_0),
    .valid_a_o  (valid_0),
    .data_b_o   (data_1),
    .valid_b_o  (valid_1)
  );

  demux1x2_8bits #(.BW(BW)) u_lane11 (
    .clk_i      (clk_2f),
    .rst_i      (reset),
    .cap_even_i (cap_even),
    .load_odd_i (load_odd),
    .data_i     (data_11),
    .valid_i    (valid_11),
    .data_a_o   (data_2),
    .valid_a_o  (valid_2),
    .data_b_o   (data_3),
    .valid_b_o  (valid_3)
  );

  assign out_stb = out_stb_q;
  assign phase   = phase_q;

endmodule
